mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the 16-bit pipelined MIPS core, directly downstream of the execute stage. Captures execute results into an internal EX/MEM register, performs loads and stores against a data memory through a request/acknowledge handshake, and stalls the pipeline while a transfer is outstanding. Resolves conditional branches for fetch and loads the MEM/WB register that feeds write-back.

## Interface
Parameters:
- DATA_W, 16, datapath and address width
- REG_ADDR_W, 3, register-file index width
- TIMEOUT, 15, watchdog limit in cycles (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  execute stage presents a valid instruction
- aluResult  in  DATA_W  ALU result / memory address
- read_data_2_ex  in  DATA_W  store data
- branch_target  in  DATA_W  branch target from execute
- zero  in  1  ALU zero flag
- write_reg_ex  in  REG_ADDR_W  destination register
- memRead, memWrite, branch, regWrite, memToReg  in  1 each  control bits
- stall_mem  out  1  upstream must hold EX outputs; combinational
- pc_src  out  1  take branch
- branch_target_mem  out  DATA_W  target for fetch
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = store
- dmem_addr  out  DATA_W  word address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  transfer complete this cycle
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack
- wb_valid  out  1  MEM/WB holds a valid instruction
- read_data_pipe_4, alu_result_pipe_4  out  DATA_W  MEM/WB data
- write_reg_pipe_4  out  REG_ADDR_W  MEM/WB destination
- regWrite_pipe_4, memToReg_pipe_4  out  1  MEM/WB control
- mem_err  out  1  sticky timeout flag

## Operation
- EX/MEM register (xm_*) loads all EX inputs on each edge where stall_mem=0; xm_valid <= ex_valid.
- mem op = xm_valid & (xm_memRead | xm_memWrite); memRead and memWrite both set is treated as a store.
- FSM states: MS_IDLE, MS_REQ.
  - IDLE -> REQ: on an edge where the EX/MEM register captures a mem op. dmem_req <= 1; dmem_we/addr/wdata driven from xm_*.
  - REQ -> IDLE: on dmem_ack, unless a new mem op is captured on the same edge, in which case the FSM stays in REQ and dmem_req stays high with the new address.
- stall_mem = (state==MS_REQ) & ~dmem_ack.
- MEM/WB loads on every edge where stall_mem=0:
  - wb_valid <= xm_valid.
  - read_data_pipe_4 <= dmem_rdata for loads, else 0.
  - Remaining fields copy xm_*.
- While stalled, MEM/WB loads a bubble: wb_valid=0, regWrite_pipe_4=0.
- pc_src = xm_valid & xm_branch & xm_zero; branch_target_mem = xm_branch_target. Both are combinational from EX/MEM.
- dmem_ack in MS_IDLE is ignored.
- Address and data are passed through unmodified at DATA_W bits. No byte lanes.

## Timing
- Reset: the FSM returns to MS_IDLE, and every register and output is 0: xm_*, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, all *_pipe_4 fields, pc_src, branch_target_mem, stall_mem, mem_err and the watchdog counter.
- Reset mid-transfer: dmem_req is 0 after the reset edge. A late ack is ignored.
- Non-memory instruction: EX input to MEM/WB output takes 2 edges.
- Memory op with ack k cycles after the req rise (k≥0 means same-cycle ack when k=0): 2+k edges.
- Back-to-back memory ops with zero-wait ack: one instruction per cycle, with dmem_req continuously high.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter runs while in MS_REQ and clears whenever the state is entered or exited.
  - If TIMEOUT cycles elapse without an ack, the transfer aborts. The FSM goes to MS_IDLE and dmem_req goes to 0.
  - MEM/WB is loaded as a normal completion, with read data 0.
  - mem_err is set to 1 and stays set until reset.
- MEM_TIMEOUT_EN undefined: the stage waits indefinitely. mem_err is tied to 0 and no counter is present.

## Structure
- Package mips16_pkg holds DATA_W, REG_ADDR_W, enum mem_state_t {MS_IDLE, MS_REQ} and the EX/MEM control struct.
- One sub-module, mem_watchdog (counter plus expiry pulse), instantiated only under MEM_TIMEOUT_EN.

## Test plan
- Stimulus: ALU op (aluResult=0x0005, regWrite=1, write_reg_ex=3). Response: after 2 edges wb_valid=1, alu_result_pipe_4=0x0005, write_reg_pipe_4=3; stall_mem stays 0.
- Stimulus: load from addr 0x0010, ack after 3 cycles with rdata 0xBEEF. Response: stall_mem high for 3 cycles; read_data_pipe_4=0xBEEF; bubbles are written to MEM/WB meanwhile.
- Stimulus: store 0x1234 to 0x0020 followed immediately by a load from 0x0022, both with zero-wait ack. Response: dmem_req stays high across both cycles; dmem_we goes 1 then 0; no stall.
- Stimulus: branch=1, zero=1, branch_target=0x0040. Response: pc_src=1 and branch_target_mem=0x0040 one edge after capture. With zero=0, pc_src=0.
- Stimulus: rst asserted during REQ, followed by a late ack. Response: all outputs are 0, the FSM is in MS_IDLE and the ack is ignored.
- Stimulus (MEM_TIMEOUT_EN): load with no ack. Response: after 15 cycles mem_err=1, wb_valid=1 with read_data_pipe_4=0, and the stall is released.

Source files
------------

// File: rtl/mips16_pkg.sv
// rtl/mips16_pkg.sv - shared widths, memory-stage FSM states and EX/MEM control bundle
package mips16_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    typedef enum logic [0:0] {
        MS_IDLE = 1'b0,
        MS_REQ  = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
        logic reg_write;
        logic mem_to_reg;
    } xm_ctrl_t;

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - cycle counter that pulses expire when a transfer waits TIMEOUT cycles
// Ports: clk, rst (sync, active-high); active = FSM in MS_REQ; ack = transfer completes;
//        expire = combinational pulse in the TIMEOUT-th waiting cycle without ack.
module mem_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // cnt counts completed waiting cycles, so the TIMEOUT-th cycle sees TIMEOUT-1
    assign expire = active & ~ack & (cnt == CW'(TIMEOUT - 1));

    // Clearing on ack/expire restarts the count for a back-to-back transfer
    always_ff @(posedge clk) begin
        if (rst || !active || ack || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS16 memory stage: EX/MEM reg, dmem handshake FSM, branch resolve, MEM/WB reg
// Optional feature: MEM_TIMEOUT_EN adds the mem_watchdog abort and sticky mem_err.
// Ports: EX inputs (ex_valid, aluResult, read_data_2_ex, branch_target, zero, write_reg_ex, controls);
//        stall_mem / pc_src / branch_target_mem back to earlier stages;
//        dmem_req/we/addr/wdata out, dmem_ack/rdata in; MEM/WB outputs (*_pipe_4, wb_valid); mem_err.
module mem_stage
    import mips16_pkg::*;
#(
    parameter int DATA_W     = mips16_pkg::DATA_W,
    parameter int REG_ADDR_W = mips16_pkg::REG_ADDR_W,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [DATA_W-1:0]     aluResult,
    input  logic [DATA_W-1:0]     read_data_2_ex,
    input  logic [DATA_W-1:0]     branch_target,
    input  logic                  zero,
    input  logic [REG_ADDR_W-1:0] write_reg_ex,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic                  branch,
    input  logic                  regWrite,
    input  logic                  memToReg,
    output logic                  stall_mem,
    output logic                  pc_src,
    output logic [DATA_W-1:0]     branch_target_mem,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  wb_valid,
    output logic [DATA_W-1:0]     read_data_pipe_4,
    output logic [DATA_W-1:0]     alu_result_pipe_4,
    output logic [REG_ADDR_W-1:0] write_reg_pipe_4,
    output logic                  regWrite_pipe_4,
    output logic                  memToReg_pipe_4,
    output logic                  mem_err
);

    mem_state_t            state;
    logic                  xm_valid;
    xm_ctrl_t              xm_ctrl;
    logic [DATA_W-1:0]     xm_alu_result;
    logic [DATA_W-1:0]     xm_branch_target;
    logic                  xm_zero;
    logic [REG_ADDR_W-1:0] xm_write_reg;

    logic expire;
    logic done;
    logic capture_mem;
    logic xm_is_load;

    // A transfer ends on ack or, when enabled, on watchdog expiry
    assign done        = dmem_ack | expire;
    assign stall_mem   = (state == MS_REQ) & ~done;
    assign capture_mem = ~stall_mem & ex_valid & (memRead | memWrite);
    // memRead together with memWrite counts as a store
    assign xm_is_load  = xm_valid & xm_ctrl.mem_read & ~xm_ctrl.mem_write;

    assign pc_src            = xm_valid & xm_ctrl.branch & xm_zero;
    assign branch_target_mem = xm_branch_target;

    // EX/MEM register: frozen while a transfer is outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            xm_valid         <= 1'b0;
            xm_ctrl          <= '0;
            xm_alu_result    <= '0;
            xm_branch_target <= '0;
            xm_zero          <= 1'b0;
            xm_write_reg     <= '0;
        end else if (!stall_mem) begin
            xm_valid         <= ex_valid;
            xm_ctrl          <= '{mem_read: memRead, mem_write: memWrite, branch: branch,
                                  reg_write: regWrite, mem_to_reg: memToReg};
            xm_alu_result    <= aluResult;
            xm_branch_target <= branch_target;
            xm_zero          <= zero;
            xm_write_reg     <= write_reg_ex;
        end
    end

    // Request FSM; a mem op captured on the completing edge keeps dmem_req high
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MS_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else if (capture_mem) begin
            state      <= MS_REQ;
            dmem_req   <= 1'b1;
            dmem_we    <= memWrite;
            dmem_addr  <= aluResult;
            dmem_wdata <= read_data_2_ex;
        end else if (state == MS_REQ && done) begin
            state    <= MS_IDLE;
            dmem_req <= 1'b0;
        end
    end

    // MEM/WB register: bubble while stalled
    always_ff @(posedge clk) begin
        if (rst || stall_mem) begin
            wb_valid          <= 1'b0;
            read_data_pipe_4  <= '0;
            alu_result_pipe_4 <= '0;
            write_reg_pipe_4  <= '0;
            regWrite_pipe_4   <= 1'b0;
            memToReg_pipe_4   <= 1'b0;
        end else begin
            wb_valid          <= xm_valid;
            // An aborted load completes with zero data
            read_data_pipe_4  <= (xm_is_load && state == MS_REQ && dmem_ack) ? dmem_rdata : '0;
            alu_result_pipe_4 <= xm_alu_result;
            write_reg_pipe_4  <= xm_write_reg;
            regWrite_pipe_4   <= xm_ctrl.reg_write;
            memToReg_pipe_4   <= xm_ctrl.mem_to_reg;
        end
    end

`ifdef MEM_TIMEOUT_EN
    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .active (state == MS_REQ),
        .ack    (dmem_ack),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_err <= 1'b0;
        end else if (expire) begin
            mem_err <= 1'b1;
        end
    end
`else
    assign expire  = 1'b0;
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [15:0] aluResult;
    logic [15:0] read_data_2_ex;
    logic [15:0] branch_target;
    logic        zero;
    logic [2:0]  write_reg_ex;
    logic        memRead, memWrite, branch, regWrite, memToReg;
    logic        stall_mem, pc_src;
    logic [15:0] branch_target_mem;
    logic        dmem_req, dmem_we;
    logic [15:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic        wb_valid;
    logic [15:0] read_data_pipe_4, alu_result_pipe_4;
    logic [2:0]  write_reg_pipe_4;
    logic        regWrite_pipe_4, memToReg_pipe_4;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    mem_stage #(.DATA_W(16), .REG_ADDR_W(3), .TIMEOUT(15)) dut (
        .clk               (clk),
        .rst               (rst),
        .ex_valid          (ex_valid),
        .aluResult         (aluResult),
        .read_data_2_ex    (read_data_2_ex),
        .branch_target     (branch_target),
        .zero              (zero),
        .write_reg_ex      (write_reg_ex),
        .memRead           (memRead),
        .memWrite          (memWrite),
        .branch            (branch),
        .regWrite          (regWrite),
        .memToReg          (memToReg),
        .stall_mem         (stall_mem),
        .pc_src            (pc_src),
        .branch_target_mem (branch_target_mem),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_ack          (dmem_ack),
        .dmem_rdata        (dmem_rdata),
        .wb_valid          (wb_valid),
        .read_data_pipe_4  (read_data_pipe_4),
        .alu_result_pipe_4 (alu_result_pipe_4),
        .write_reg_pipe_4  (write_reg_pipe_4),
        .regWrite_pipe_4   (regWrite_pipe_4),
        .memToReg_pipe_4   (memToReg_pipe_4),
        .mem_err           (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid       = 1'b0;
        aluResult      = '0;
        read_data_2_ex = '0;
        branch_target  = '0;
        zero           = 1'b0;
        write_reg_ex   = '0;
        memRead        = 1'b0;
        memWrite       = 1'b0;
        branch         = 1'b0;
        regWrite       = 1'b0;
        memToReg       = 1'b0;
        dmem_ack       = 1'b0;
        dmem_rdata     = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_stall", stall_mem, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_pc_src", pc_src, 0);
        chk("rst_mem_err", mem_err, 0);
        rst = 1'b0;

        // ALU op: 2 edges to MEM/WB
        ex_valid = 1; aluResult = 16'h0005; regWrite = 1; write_reg_ex = 3'd3;
        tick();
        idle_inputs();
        #1;
        chk("alu_stall", stall_mem, 0);
        chk("alu_wb_early", wb_valid, 0);
        tick();
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_result", alu_result_pipe_4, 16'h0005);
        chk("alu_wreg", write_reg_pipe_4, 3);
        chk("alu_regwrite", regWrite_pipe_4, 1);
        chk("alu_no_req", dmem_req, 0);

        // Load from 0x0010, ack in the 4th REQ cycle (k=3)
        ex_valid = 1; memRead = 1; memToReg = 1; regWrite = 1;
        write_reg_ex = 3'd2; aluResult = 16'h0010;
        tick();
        idle_inputs();
        #1;
        chk("ld_req", dmem_req, 1);
        chk("ld_we", dmem_we, 0);
        chk("ld_addr", dmem_addr, 16'h0010);
        chk("ld_stall_c1", stall_mem, 1);
        tick();
        chk("ld_stall_c2", stall_mem, 1);
        chk("ld_bubble_c2", wb_valid, 0);
        tick();
        chk("ld_stall_c3", stall_mem, 1);
        chk("ld_bubble_c3", wb_valid, 0);
        tick();
        dmem_ack = 1; dmem_rdata = 16'hBEEF;
        #1;
        chk("ld_stall_ack", stall_mem, 0);
        tick();
        dmem_ack = 0; dmem_rdata = '0;
        #1;
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_rdata", read_data_pipe_4, 16'hBEEF);
        chk("ld_wreg", write_reg_pipe_4, 2);
        chk("ld_memtoreg", memToReg_pipe_4, 1);
        chk("ld_req_drop", dmem_req, 0);

        // Store 0x1234 @0x0020 then load @0x0022, zero-wait
        ex_valid = 1; memWrite = 1; aluResult = 16'h0020; read_data_2_ex = 16'h1234;
        tick();
        idle_inputs();
        ex_valid = 1; memRead = 1; regWrite = 1; write_reg_ex = 3'd5; aluResult = 16'h0022;
        dmem_ack = 1;
        #1;
        chk("st_req", dmem_req, 1);
        chk("st_we", dmem_we, 1);
        chk("st_addr", dmem_addr, 16'h0020);
        chk("st_wdata", dmem_wdata, 16'h1234);
        chk("st_stall", stall_mem, 0);
        tick();
        idle_inputs();
        dmem_ack = 1; dmem_rdata = 16'hCAFE;
        #1;
        chk("b2b_req", dmem_req, 1);
        chk("b2b_we", dmem_we, 0);
        chk("b2b_addr", dmem_addr, 16'h0022);
        chk("b2b_stall", stall_mem, 0);
        chk("st_wb_valid", wb_valid, 1);
        chk("st_wb_rdata", read_data_pipe_4, 0);
        chk("st_wb_regwrite", regWrite_pipe_4, 0);
        tick();
        dmem_ack = 0; dmem_rdata = '0;
        #1;
        chk("b2b_wb_valid", wb_valid, 1);
        chk("b2b_rdata", read_data_pipe_4, 16'hCAFE);
        chk("b2b_wreg", write_reg_pipe_4, 5);
        chk("b2b_req_drop", dmem_req, 0);

        // Branch taken then not taken
        ex_valid = 1; branch = 1; zero = 1; branch_target = 16'h0040;
        #1;
        chk("br_pre", pc_src, 0);
        tick();
        chk("br_taken", pc_src, 1);
        chk("br_target", branch_target_mem, 16'h0040);
        zero = 0; branch_target = 16'h0080;
        tick();
        chk("br_not_taken", pc_src, 0);
        chk("br_target2", branch_target_mem, 16'h0080);
        idle_inputs();
        tick();

        // Reset during REQ, then a late ack
        ex_valid = 1; memRead = 1; regWrite = 1; aluResult = 16'h0030; write_reg_ex = 3'd1;
        tick();
        idle_inputs();
        #1;
        chk("rr_req", dmem_req, 1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("rr_req0", dmem_req, 0);
        chk("rr_addr0", dmem_addr, 0);
        chk("rr_stall0", stall_mem, 0);
        chk("rr_wb0", wb_valid, 0);
        dmem_ack = 1; dmem_rdata = 16'h5555;
        #1;
        chk("rr_late_stall", stall_mem, 0);
        tick();
        dmem_ack = 0; dmem_rdata = '0;
        #1;
        chk("rr_late_wb", wb_valid, 0);
        chk("rr_late_rdata", read_data_pipe_4, 0);
        chk("rr_late_req", dmem_req, 0);

        // Load with no ack
        ex_valid = 1; memRead = 1; regWrite = 1; aluResult = 16'h0044; write_reg_ex = 3'd4;
        tick();
        idle_inputs();
        #1;
`ifdef MEM_TIMEOUT_EN
        for (int i = 1; i <= 14; i++) begin
            chk($sformatf("to_stall_c%0d", i), stall_mem, 1);
            chk($sformatf("to_err_c%0d", i), mem_err, 0);
            tick();
        end
        chk("to_release", stall_mem, 0);
        tick();
        chk("to_mem_err", mem_err, 1);
        chk("to_wb_valid", wb_valid, 1);
        chk("to_rdata", read_data_pipe_4, 0);
        chk("to_req", dmem_req, 0);
        tick();
        tick();
        chk("to_err_sticky", mem_err, 1);
`else
        for (int i = 1; i <= 20; i++) begin
            chk($sformatf("wait_stall_c%0d", i), stall_mem, 1);
            tick();
        end
        chk("wait_mem_err", mem_err, 0);
        dmem_ack = 1; dmem_rdata = 16'h00A5;
        tick();
        dmem_ack = 0; dmem_rdata = '0;
        #1;
        chk("wait_wb_valid", wb_valid, 1);
        chk("wait_rdata", read_data_pipe_4, 16'h00A5);
        chk("wait_req", dmem_req, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
